// File: rtl/pe_row_driver.sv
// Drives one external PE: reads a weight row and a pixel stream, then sequences
// the multiply-accumulates for a 1-D valid convolution, one output at a time.
module pe_row_driver #(
    parameter int unsigned KW     = 3,
    parameter int unsigned DW     = 16,
    parameter int unsigned PW     = 32,
    parameter int unsigned PE_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    row_len,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic          w_valid,
    output logic          w_ready,
    input  logic [DW-1:0] w_data,
    input  logic          px_valid,
    output logic          px_ready,
    input  logic [DW-1:0] px_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data,
    output logic [DW-1:0] pe_weight_val,
    output logic          pe_weight_en,
    output logic [DW-1:0] pe_image_val,
    output logic          pe_image_en,
    output logic [PW-1:0] pe_psum_in,
    input  logic [PW-1:0] pe_psum_out
);

    localparam int unsigned KIW = (KW > 1) ? $clog2(KW) : 1;
    localparam int unsigned LW  = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_W, S_FILL, S_MAC_W, S_MAC_X, S_WAIT, S_OUT, S_SHIFT, S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   w_q   [KW];
    logic [DW-1:0]   w_d   [KW];
    logic [DW-1:0]   win_q [KW];
    logic [DW-1:0]   win_d [KW];
    logic [PW-1:0]   acc_q, acc_d;
    logic [KIW-1:0]  k_q, k_d;
    logic [KIW-1:0]  cnt_q, cnt_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic [7:0]      rem_q, rem_d;
    logic            err_d;

    logic            busy_q, done_q, err_q, w_ready_q, px_ready_q, out_valid_q;
    logic            pe_weight_en_q, pe_image_en_q;
    logic [PW-1:0]   out_data_q, pe_psum_in_q;
    logic [DW-1:0]   pe_weight_val_q, pe_image_val_q;

    // Next-state and datapath updates; rem_q counts outputs still owed after the current one.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        win_d   = win_q;
        acc_d   = acc_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        rem_d   = rem_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (row_len >= 8'(KW)) begin
                        state_d = S_LOAD_W;
                        cnt_d   = '0;
                        rem_d   = row_len - 8'(KW);
                    end else begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_LOAD_W: begin
                if (w_valid) begin
                    w_d[cnt_q] = w_data;
                    if (cnt_q == KIW'(KW - 1)) begin
                        cnt_d   = '0;
                        state_d = S_FILL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FILL: begin
                if (px_valid) begin
                    win_d[cnt_q] = px_data;
                    if (cnt_q == KIW'(KW - 1)) begin
                        cnt_d   = '0;
                        k_d     = '0;
                        acc_d   = '0;
                        state_d = S_MAC_W;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_MAC_W: state_d = S_MAC_X;
            S_MAC_X: begin
                lat_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == LW'(PE_LAT - 1)) begin
                    acc_d = pe_psum_out;
                    if (k_q == KIW'(KW - 1)) begin
                        state_d = S_OUT;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = S_MAC_W;
                    end
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (rem_q != 8'd0) begin
                        rem_d   = rem_q - 8'd1;
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                if (px_valid) begin
                    for (int i = 0; i < int'(KW) - 1; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[KW-1] = px_data;
                    k_d         = '0;
                    acc_d       = '0;
                    state_d     = S_MAC_W;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs; outputs are decoded from the next state
    // so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            w_q             <= '{default: '0};
            win_q           <= '{default: '0};
            acc_q           <= '0;
            k_q             <= '0;
            cnt_q           <= '0;
            lat_q           <= '0;
            rem_q           <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            w_ready_q       <= 1'b0;
            px_ready_q      <= 1'b0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            pe_weight_en_q  <= 1'b0;
            pe_weight_val_q <= '0;
            pe_image_en_q   <= 1'b0;
            pe_image_val_q  <= '0;
            pe_psum_in_q    <= '0;
        end else begin
            state_q         <= state_d;
            w_q             <= w_d;
            win_q           <= win_d;
            acc_q           <= acc_d;
            k_q             <= k_d;
            cnt_q           <= cnt_d;
            lat_q           <= lat_d;
            rem_q           <= rem_d;
            busy_q          <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q          <= (state_d == S_DONE);
            err_q           <= err_d;
            w_ready_q       <= (state_d == S_LOAD_W);
            px_ready_q      <= (state_d == S_FILL) || (state_d == S_SHIFT);
            out_valid_q     <= (state_d == S_OUT);
            out_data_q      <= (state_d == S_OUT) ? acc_d : '0;
            pe_weight_en_q  <= (state_d == S_MAC_W);
            pe_weight_val_q <= (state_d == S_MAC_W) ? w_d[k_d] : '0;
            pe_image_en_q   <= (state_d == S_MAC_X);
            pe_image_val_q  <= (state_d == S_MAC_X) ? win_d[k_d] : '0;
            pe_psum_in_q    <= (state_d == S_MAC_X) ? acc_d : '0;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign w_ready       = w_ready_q;
    assign px_ready      = px_ready_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign pe_weight_en  = pe_weight_en_q;
    assign pe_weight_val = pe_weight_val_q;
    assign pe_image_en   = pe_image_en_q;
    assign pe_image_val  = pe_image_val_q;
    assign pe_psum_in    = pe_psum_in_q;

endmodule

// File: tb/tb_pe_row_driver.sv
// Bench for pe_row_driver: ideal one-cycle PE, random stream handshakes, and a
// scoreboard fed by a plain-arithmetic convolution model.
module tb_pe_row_driver;

    localparam int KW     = 3;
    localparam int DW     = 16;
    localparam int PW     = 32;
    localparam int PE_LAT = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    row_len = 8'd0;
    logic          busy, done, err;
    logic          w_valid = 1'b0;
    logic          w_ready;
    logic [DW-1:0] w_data = '0;
    logic          px_valid = 1'b0;
    logic          px_ready;
    logic [DW-1:0] px_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [PW-1:0] out_data;
    logic [DW-1:0] pe_weight_val, pe_image_val;
    logic          pe_weight_en, pe_image_en;
    logic [PW-1:0] pe_psum_in;
    logic [PW-1:0] pe_psum_out;

    always #5 clk = ~clk;

    pe_row_driver #(.KW(KW), .DW(DW), .PW(PW), .PE_LAT(PE_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .row_len(row_len),
        .busy(busy), .done(done), .err(err),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .pe_weight_val(pe_weight_val), .pe_weight_en(pe_weight_en),
        .pe_image_val(pe_image_val), .pe_image_en(pe_image_en),
        .pe_psum_in(pe_psum_in), .pe_psum_out(pe_psum_out)
    );

    // Ideal PE: weight latched on pe_weight_en, result one cycle after pe_image_en.
    logic [DW-1:0] pe_w_reg = '0;
    logic [PW-1:0] pe_res   = '0;
    always @(posedge clk) begin
        if (pe_weight_en) pe_w_reg <= pe_weight_val;
        if (pe_image_en)  pe_res   <= PW'(pe_w_reg) * PW'(pe_image_val) + pe_psum_in;
    end
    assign pe_psum_out = pe_res;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    logic [DW-1:0] wq[$];
    logic [DW-1:0] pq[$];
    logic [PW-1:0] expq[$];
    logic          errq[$];
    logic [DW-1:0] cur_w[$];
    logic [DW-1:0] cur_x[$];
    logic [PW-1:0] dir_exp[$];
    int done_cnt = 0;
    int out_cnt  = 0;
    int ready_mode = 0;
    int stall_left = 0;

    // Reference: out[j] = sum_k w[k]*x[j+k], modulo 2^32.
    function automatic logic [31:0] ref_out(input int j);
        logic [31:0] s = 32'd0;
        for (int k = 0; k < KW; k++) s = s + 32'(cur_w[k]) * 32'(cur_x[j+k]);
        return s;
    endfunction

    // Weight stream source.
    always begin
        @(negedge clk);
        if (w_valid && w_ready && wq.size() > 0) void'(wq.pop_front());
        @(posedge clk);
        #1;
        if (wq.size() > 0 && $urandom_range(3) != 0) begin
            w_valid = 1'b1;
            w_data  = wq[0];
        end else begin
            w_valid = 1'b0;
        end
    end

    // Pixel stream source.
    always begin
        @(negedge clk);
        if (px_valid && px_ready && pq.size() > 0) void'(pq.pop_front());
        @(posedge clk);
        #1;
        if (pq.size() > 0 && $urandom_range(3) != 0) begin
            px_valid = 1'b1;
            px_data  = pq[0];
        end else begin
            px_valid = 1'b0;
        end
    end

    // Result sink back-pressure.
    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(1));
            default: begin
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    if (out_valid) stall_left--;
                end else begin
                    out_ready = 1'b1;
                end
            end
        endcase
    end

    // Monitor: scoreboard, done/err, PE enable exclusivity and per-output MAC latency.
    int  cyc = 0;
    int  wen_cnt = 0;
    int  t0 = 0;
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            wen_cnt = 0;
            prev_ov = 1'b0;
        end else begin
            if (pe_weight_en || pe_image_en)
                check("pe_en_exclusive", 32'(pe_weight_en & pe_image_en), 32'd0);
            if (pe_weight_en) begin
                if (wen_cnt % KW == 0) t0 = cyc;
                wen_cnt++;
            end
            if (out_valid && !prev_ov)
                check("mac_latency", 32'(cyc - t0), 32'(KW * (2 + PE_LAT)));
            if (out_valid) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    $display("FAIL out_unexpected: got out_data 0x%0h, expected no output", out_data);
                end else begin
                    check("out_data", out_data, expq[0]);
                    if (out_ready) begin
                        void'(expq.pop_front());
                        out_cnt++;
                    end
                end
            end
            prev_ov = out_valid;
            if (done) begin
                check("busy_at_done", 32'(busy), 32'd0);
                if (errq.size() == 0) begin
                    n_checks++;
                    $display("FAIL done_unexpected: got done=1, expected no done");
                end else begin
                    check("err_at_done", 32'(err), 32'(errq.pop_front()));
                end
                done_cnt++;
            end
        end
    end

    task automatic load_row(input int len, input bit use_dir);
        if (len >= KW) begin
            foreach (cur_w[i]) wq.push_back(cur_w[i]);
            foreach (cur_x[i]) pq.push_back(cur_x[i]);
            if (use_dir) foreach (dir_exp[i]) expq.push_back(dir_exp[i]);
            else for (int j = 0; j <= len - KW; j++) expq.push_back(ref_out(j));
            errq.push_back(1'b0);
        end else begin
            errq.push_back(1'b1);
        end
    endtask

    task automatic set_basic();
        cur_w.delete(); cur_x.delete(); dir_exp.delete();
        for (int i = 1; i <= 3; i++) cur_w.push_back(DW'(i));
        for (int i = 1; i <= 5; i++) cur_x.push_back(DW'(i));
        dir_exp.push_back(32'd14); dir_exp.push_back(32'd20); dir_exp.push_back(32'd26);
    endtask

    task automatic pulse_start(input int len);
        @(posedge clk);
        #1;
        row_len = 8'(len);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(done_cnt), 32'(target));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 32'({busy, done, err, w_ready, px_ready, out_valid,
                                   pe_weight_en, pe_image_en}), 32'd0);
        check({tag, "_out_data"}, out_data, 32'd0);
        check({tag, "_pe_vals"}, 32'({pe_weight_val, pe_image_val}), 32'd0);
        check({tag, "_psum_in"}, pe_psum_in, 32'd0);
    endtask

    initial begin
        int base, n, len;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic row, then the same row with a long stall on the first output.
        set_basic();
        load_row(5, 1'b1);
        pulse_start(5);
        wait_done(1, 2000, "basic_done");
        check("basic_drained", 32'(expq.size()), 32'd0);

        ready_mode = 2;
        stall_left = 10;
        load_row(5, 1'b1);
        pulse_start(5);
        wait_done(2, 2000, "stall_done");
        check("stall_drained", 32'(expq.size()), 32'd0);
        ready_mode = 0;

        // Short row: immediate err, no stream or PE activity.
        base = done_cnt;
        load_row(2, 1'b0);
        @(posedge clk);
        #1;
        row_len = 8'd2;
        start   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("short_quiet", 32'({w_ready, px_ready, pe_weight_en, pe_image_en}), 32'd0);
            if (i == 0) begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        check("short_done_in_time", 32'(done_cnt), 32'(base + 1));

        // Wrap-around of the accumulator.
        cur_w.delete(); cur_x.delete(); dir_exp.delete();
        for (int i = 0; i < 3; i++) begin
            cur_w.push_back(16'hFFFF);
            cur_x.push_back(16'hFFFF);
        end
        dir_exp.push_back(32'hFFFA0003);
        load_row(3, 1'b1);
        pulse_start(3);
        wait_done(base + 2, 2000, "wrap_done");

        // Reset during the second MAC_X aborts the row with no done pulse.
        set_basic();
        load_row(5, 1'b1);
        base = done_cnt;
        pulse_start(5);
        n = 0;
        for (int i = 0; i < 2000 && n < 2; i++) begin
            @(negedge clk);
            if (pe_image_en) n++;
        end
        check("abort_reached_mac_x", 32'(n), 32'd2);
        rst = 1'b1;
        wq.delete(); pq.delete(); expq.delete(); errq.delete();
        @(posedge clk);
        @(negedge clk);
        check_all_zero("abort");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(base));
        load_row(5, 1'b1);
        pulse_start(5);
        wait_done(base + 1, 2000, "after_abort_done");
        check("after_abort_drained", 32'(expq.size()), 32'd0);

        // Second start while busy is ignored.
        base = done_cnt;
        n    = out_cnt;
        load_row(5, 1'b1);
        pulse_start(5);
        repeat (8) @(negedge clk);
        check("busy_mid_row", 32'(busy), 32'd1);
        pulse_start(5);
        wait_done(base + 1, 2000, "restart_done");
        repeat (40) @(negedge clk);
        check("restart_one_done", 32'(done_cnt), 32'(base + 1));
        check("restart_three_outs", 32'(out_cnt - n), 32'd3);

        // Random rows with random back-pressure.
        ready_mode = 1;
        for (int r = 0; r < 20; r++) begin
            len = $urandom_range(9);
            cur_w.delete(); cur_x.delete();
            for (int i = 0; i < KW; i++) cur_w.push_back(16'($urandom_range(65535)));
            for (int i = 0; i < len; i++) cur_x.push_back(16'($urandom_range(65535)));
            base = done_cnt;
            load_row(len, 1'b0);
            pulse_start(len);
            wait_done(base + 1, 4000, "rand_done");
        end
        repeat (5) @(negedge clk);
        check("final_exp_empty", 32'(expq.size()), 32'd0);
        check("final_err_empty", 32'(errq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pe_row_driver.md
PE_ROW_DRIVER -- requirements
Module: pe_row_driver

Interface
REQ-001 Parameters: KW, default 3, filter taps per output (range 1..8).
REQ-002 Parameters: DW, default 16, image/weight width.
REQ-003 Parameters: PW, default 32, psum width.
REQ-004 Parameters: PE_LAT, default 1, cycles from pe_image_en high to valid pe_psum_out (1..4).
REQ-005 Ports (name, direction, width, meaning):
- clk, in, 1, the only clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, begin one row.
- row_len, in, 8, pixel count, sampled with start.
- busy, out, 1, row in progress.
- done, out, 1, one-cycle end-of-row pulse.
- err, out, 1, valid with done; row_len < KW.
- w_valid / w_ready / w_data, in / out / in, 1 / 1 / DW, weight stream.
- px_valid / px_ready / px_data, in / out / in, 1 / 1 / DW, pixel stream.
- out_valid / out_ready / out_data, out / in / out, 1 / 1 / PW, result stream.
- pe_weight_val / pe_weight_en, out, DW / 1, PE weight load.
- pe_image_val / pe_image_en, out, DW / 1, PE image issue.
- pe_psum_in, out, PW, PE partial-sum input.
- pe_psum_out, in, PW, PE result (pe_weight_val * pe_image_val + pe_psum_in).

Function
REQ-006 The block SHALL drive one PE and compute a 1-D valid convolution: out[j] = sum over k=0..KW-1 of w[k]*x[j+k], for j = 0..row_len-KW.
REQ-007 FSM states SHALL be IDLE, LOAD_W, FILL, MAC_W, MAC_X, WAIT, OUT, SHIFT, DONE.
REQ-008 IDLE: on start with row_len >= KW -> LOAD_W, busy=1; on start with row_len < KW -> DONE with err=1 and no PE, weight or pixel activity.
REQ-009 LOAD_W: w_ready=1; accept KW weights in order into w[0..KW-1], then -> FILL.
REQ-010 FILL: px_ready=1; accept KW pixels into window x[0..KW-1], oldest at index 0; set k=0, acc=0, then -> MAC_W.
REQ-011 MAC_W: assert pe_weight_en=1 for exactly one cycle with pe_weight_val=w[k], then -> MAC_X.
REQ-012 MAC_X: assert pe_image_en=1 for exactly one cycle with pe_image_val=window[k] and pe_psum_in=acc, then -> WAIT.
REQ-013 WAIT: hold PE_LAT cycles, counting from the cycle after MAC_X inclusive; on the last cycle, acc <= pe_psum_out; if k<KW-1 then k++ and -> MAC_W, else -> OUT.
REQ-014 Each output therefore SHALL take exactly KW*(2+PE_LAT) cycles from the first MAC_W to the OUT entry.
REQ-015 OUT: out_valid=1, out_data=acc, both held stable until out_ready=1; if more outputs remain -> SHIFT, else -> DONE.
REQ-016 SHIFT: px_ready=1; on the px handshake the window shifts down one position with the new pixel at index KW-1; k=0, acc=0, -> MAC_W.
REQ-017 DONE: done=1 for one cycle, busy=0 in the same cycle, -> IDLE.
REQ-018 w_ready and px_ready SHALL be 0 in all states except those named above; stalls on w_valid, px_valid or out_ready SHALL extend the current state indefinitely without corrupting data.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 pe_weight_en and pe_image_en SHALL never be high in the same cycle; both SHALL be 0 outside MAC_W and MAC_X respectively.
REQ-021 Accumulation SHALL wrap modulo 2^PW; products are unsigned.
REQ-022 Each start SHALL reload the weights; values from the previous row SHALL NOT be reused.

Reset
REQ-023 On rst: state=IDLE; busy, done, err, w_ready, px_ready, out_valid, pe_weight_en and pe_image_en = 0; all data outputs, the w/window registers, acc and k = 0.
REQ-024 rst asserted mid-row SHALL abort the row in the next cycle with no done pulse; any pending output is discarded.

Verification (ideal PE model, KW=3, PE_LAT=1)
REQ-025 Weights 1,2,3, pixels 1..5, row_len=5, out_ready=1 -> outputs 14, 20, 26, then a done pulse with err=0.
REQ-026 Same stimulus with out_ready low for 10 cycles at the first out_valid -> out_data held at 14 throughout; output sequence unchanged.
REQ-027 row_len=2 -> done=1 and err=1 within 2 cycles of start; w_ready, px_ready, pe_weight_en and pe_image_en remain 0.
REQ-028 Weights 0xFFFF x3, pixels 0xFFFF x3, row_len=3 -> out_data = 3*0xFFFE0001 mod 2^32 = 0xFFFA0003.
REQ-029 rst asserted during the second MAC_X -> all outputs 0 next cycle; a fresh start then reproduces the REQ-025 results.
REQ-030 Second start pulse issued while busy -> ignored; exactly 3 outputs and one done pulse.
